dm_port_arbiter: RTL and testbench
==================================

// Module: dm_port_arbiter
// PURPOSE
//  Arbitrates the single-ported 16-bit memory between the MEM stage (dm_re/dm_we/dm_addr/dm_in)
//  and instruction fetch (if_re/if_addr). Drives a multi-cycle memory handshake (mem_req/mem_ready).
//  Returns read data and a one-cycle done pulse to each requester, plus stall while either waits.
//  Bounds data-side starvation of fetch and aborts memory accesses that never complete.
// PARAMETERS
//  STARVE_MAX  4    consecutive data grants allowed while if_re waits before fetch is forced (>=1)
//  TIMEOUT     255  cycles in BUSY without mem_ready before the access is aborted (1..255)
// PORTS
//  clk        in   1   clock, all state on rising edge
//  rst        in   1   synchronous reset, active-high
//  dm_re      in   1   MEM-stage read request (LW, RET); held until dm_done
//  dm_we      in   1   MEM-stage write request (SW, CALL); held until dm_done
//  dm_addr    in   16  data address
//  dm_in      in   16  write data
//  dm_out     out  16  registered read data of the last completed data read
//  dm_done    out  1   one-cycle pulse: data access completed (or aborted)
//  if_re      in   1   fetch request; held until if_done
//  if_addr    in   16  fetch address (PC)
//  instr_out  out  16  registered fetched instruction
//  if_done    out  1   one-cycle pulse: fetch completed (or aborted)
//  stall      out  1   (dm_re|dm_we) & ~dm_done | if_re & ~if_done  (combinational)
//  mem_req    out  1   memory access strobe
//  mem_we     out  1   1 = write, 0 = read; valid while mem_req
//  mem_addr   out  16  memory address; valid while mem_req
//  mem_wdata  out  16  memory write data; valid while mem_req & mem_we
//  mem_rdata  in   16  memory read data; sampled when mem_ready
//  mem_ready  in   1   memory accepts/completes the access this cycle
//  err        out  1   one-cycle pulse, coincident with done, when an access timed out
// BEHAVIOUR
//  Reset: state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, dm_out=0, instr_out=0,
//   dm_done=0, if_done=0, err=0, starve_cnt=0, timer=0. Reset mid-access abandons it; no done.
//  FSM states IDLE, BUSY_D, BUSY_I.
//  IDLE: eligible data = (dm_re|dm_we) & ~dm_done; eligible fetch = if_re & ~if_done.
//   The ~done terms stop a request being re-issued in the cycle its done pulse is visible.
//   Data wins unless fetch is eligible and starve_cnt==STARVE_MAX; then fetch wins.
//   Grant: register mem_req=1 and mem_addr/mem_we/mem_wdata; go BUSY_D or BUSY_I; timer=0.
//   dm_we & dm_re both high -> write performed, read ignored (dm_out unchanged).
//  BUSY_x: mem_req and address/we/data held stable. timer increments each cycle.
//   On mem_ready=1: mem_req drops next edge; capture mem_rdata into dm_out (data read) or
//   instr_out (fetch); pulse dm_done/if_done the next cycle; return to IDLE.
//   If timer reaches TIMEOUT with no mem_ready: drop mem_req, pulse done+err, leave data regs unchanged.
//  Minimum latency: grant edge -> mem_ready in the first BUSY cycle -> done high 2 cycles after request.
//  starve_cnt: +1 (saturating at STARVE_MAX) on each data grant while fetch is eligible;
//   cleared on a fetch grant or whenever if_re=0.
//  Done/err are registered pulses of exactly one cycle. mem_ready outside BUSY is ignored.
//  Requester inputs are sampled only at grant; later changes have no effect until done.
// TESTING
//  1 Fetch only: if_re=1, if_addr=0x0010, mem_ready at first BUSY cycle, mem_rdata=0xA123 ->
//    mem_req 1 cycle, if_done 2 cycles after request, instr_out=0xA123, stall low after done.
//  2 Data write vs fetch: dm_we=1, dm_addr=0x00F0, dm_in=0x5555 plus if_re same cycle -> write first
//    (mem_we=1, mem_wdata=0x5555), then fetch; exactly one dm_done and one if_done.
//  3 Starvation: dm_re held with back-to-back new requests, if_re=1 -> after 4 data grants the next
//    grant is fetch; starve_cnt back to 0.
//  4 Wait states: LW at 0x0100, mem_ready delayed 5 cycles, mem_rdata=0xBEEF -> mem_addr stable
//    all 5 cycles, dm_out=0xBEEF, stall high throughout.
//  5 Timeout: mem_ready never asserted -> after 255 BUSY cycles mem_req drops, dm_done & err pulse,
//    dm_out keeps prior value; rst asserted mid-BUSY -> mem_req=0 next edge, no done pulse.

Source files
------------

// File: rtl/dm_port_arbiter.sv
// Single-port memory arbiter between the MEM-stage data port and instruction fetch.
// Data normally wins; a starvation counter forces fetch, and a watchdog aborts stuck accesses.
module dm_port_arbiter #(
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dm_re,
  input  logic        dm_we,
  input  logic [15:0] dm_addr,
  input  logic [15:0] dm_in,
  output logic [15:0] dm_out,
  output logic        dm_done,
  input  logic        if_re,
  input  logic [15:0] if_addr,
  output logic [15:0] instr_out,
  output logic        if_done,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ready,
  output logic        err
);

  localparam int unsigned SW       = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] S_MAX  = SW'(STARVE_MAX);
  localparam logic [7:0]  TMR_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUSY_D, BUSY_I} state_t;

  state_t        state, state_n;
  logic          mem_req_n, mem_we_n;
  logic [15:0]   mem_addr_n, mem_wdata_n, dm_out_n, instr_out_n;
  logic          dm_done_n, if_done_n, err_n;
  logic [SW-1:0] starve_cnt, starve_n;
  logic [7:0]    timer, timer_n;

  logic dm_elig, if_elig, fetch_wins;

  // The ~done terms keep a still-held request from being re-issued in its own done cycle.
  assign dm_elig    = (dm_re | dm_we) & ~dm_done;
  assign if_elig    = if_re & ~if_done;
  assign fetch_wins = if_elig & (~dm_elig | (starve_cnt == S_MAX));

  assign stall = ((dm_re | dm_we) & ~dm_done) | (if_re & ~if_done);

  // NOTE: every variable gets a default before the case so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_n     = state;
    mem_req_n   = mem_req;
    mem_we_n    = mem_we;
    mem_addr_n  = mem_addr;
    mem_wdata_n = mem_wdata;
    dm_out_n    = dm_out;
    instr_out_n = instr_out;
    dm_done_n   = 1'b0;
    if_done_n   = 1'b0;
    err_n       = 1'b0;
    starve_n    = starve_cnt;
    timer_n     = timer;

    case (state)
      IDLE: begin
        if (fetch_wins) begin
          state_n    = BUSY_I;
          mem_req_n  = 1'b1;
          mem_we_n   = 1'b0;
          mem_addr_n = if_addr;
          timer_n    = '0;
          starve_n   = '0;
        end else if (dm_elig) begin
          state_n     = BUSY_D;
          mem_req_n   = 1'b1;
          mem_we_n    = dm_we;
          mem_addr_n  = dm_addr;
          mem_wdata_n = dm_in;
          timer_n     = '0;
          if (if_elig && starve_cnt != S_MAX) starve_n = starve_cnt + SW'(1);
        end
      end

      BUSY_D, BUSY_I: begin
        if (mem_ready || timer == TMR_LAST) begin
          state_n   = IDLE;
          mem_req_n = 1'b0;
          err_n     = ~mem_ready;
          if (state == BUSY_I) begin
            if_done_n = 1'b1;
            if (mem_ready) instr_out_n = mem_rdata;
          end else begin
            dm_done_n = 1'b1;
            // A write (including write+read) never updates the read-data register.
            if (mem_ready && !mem_we) dm_out_n = mem_rdata;
          end
        end else begin
          timer_n = timer + 8'd1;
        end
      end

      default: state_n = IDLE;
    endcase

    if (!if_re) starve_n = '0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge value regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      dm_out     <= '0;
      instr_out  <= '0;
      dm_done    <= 1'b0;
      if_done    <= 1'b0;
      err        <= 1'b0;
      starve_cnt <= '0;
      timer      <= '0;
    end else begin
      state      <= state_n;
      mem_req    <= mem_req_n;
      mem_we     <= mem_we_n;
      mem_addr   <= mem_addr_n;
      mem_wdata  <= mem_wdata_n;
      dm_out     <= dm_out_n;
      instr_out  <= instr_out_n;
      dm_done    <= dm_done_n;
      if_done    <= if_done_n;
      err        <= err_n;
      starve_cnt <= starve_n;
      timer      <= timer_n;
    end
  end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Randomized scoreboard bench for dm_port_arbiter: two requester threads, a memory
// responder with random wait states, and a monitor that checks results and arbitration rules.
module tb_dm_port_arbiter;

  localparam int STARVE_MAX = 4;
  localparam int TIMEOUT    = 255;
  localparam int N_OPS      = 60;
  localparam int WAIT_MAX   = 2000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dm_re = 1'b0, dm_we = 1'b0, if_re = 1'b0;
  logic [15:0] dm_addr = '0, dm_in = '0, if_addr = '0;
  logic [15:0] dm_out, instr_out, mem_addr, mem_wdata;
  logic        dm_done, if_done, stall, mem_req, mem_we, err;
  logic [15:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;

  always #5 clk = ~clk;

  dm_port_arbiter #(.STARVE_MAX(STARVE_MAX), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .dm_re(dm_re), .dm_we(dm_we), .dm_addr(dm_addr), .dm_in(dm_in),
    .dm_out(dm_out), .dm_done(dm_done),
    .if_re(if_re), .if_addr(if_addr), .instr_out(instr_out), .if_done(if_done),
    .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .err(err)
  );

  typedef struct {
    logic [15:0] addr;
    logic        we;
    logic [15:0] wdata;
    logic [15:0] out;
    logic        err;
  } exp_t;

  exp_t dq[$];
  exp_t iq[$];
  int vectors = 0;
  int miscompares = 0;

  // Data region 0x80xx is RAM, fetch region 0x00xx is a fixed code pattern;
  // any address with bit 12 set is a hole the memory never acknowledges.
  logic [15:0] phys_mem [256];
  logic [15:0] ref_mem  [256];

  function automatic logic [15:0] code_word(input logic [15:0] a);
    return {a[7:0], ~a[7:0]} ^ 16'h1234;
  endfunction

  task automatic check(input string name, input logic ok, input string detail);
    vectors++;
    if (ok !== 1'b1) begin
      miscompares++;
      $display("FAIL %s: %s", name, detail);
    end
  endtask

  // Memory responder: random wait states, random noise on mem_ready while idle.
  int resp_cnt = 0, resp_lat = 0, last_lat = 0;
  bit resp_active = 1'b0;
  always @(posedge clk) begin
    #1;
    if (mem_req) begin
      if (!resp_active) begin
        resp_active = 1'b1;
        resp_cnt    = 0;
        resp_lat    = $urandom_range(0, 4);
        last_lat    = resp_lat;
      end
      if (resp_cnt == resp_lat && !mem_addr[12]) begin
        mem_ready = 1'b1;
        if (!mem_addr[15])  mem_rdata = code_word(mem_addr);
        else if (!mem_we)   mem_rdata = phys_mem[mem_addr[7:0]];
        else begin
          phys_mem[mem_addr[7:0]] = mem_wdata;
          mem_rdata = 16'($urandom);
        end
      end else begin
        mem_ready = 1'b0;
        mem_rdata = 16'($urandom);
      end
      resp_cnt++;
    end else begin
      resp_active = 1'b0;
      mem_ready   = 1'($urandom_range(0, 1));
      mem_rdata   = 16'($urandom);
    end
  end

  // Monitor: per-cycle protocol, arbitration rules and scoreboard pops on done pulses.
  logic p_req = 1'b0, p_dm_done = 1'b0, p_if_done = 1'b0, p_rst = 1'b1, p_if_re = 1'b0;
  logic p_dm_elig = 1'b0, p_if_elig = 1'b0;
  int   starve = 0;
  logic [15:0] rec_addr = '0, rec_wdata = '0;
  logic rec_we = 1'b0;
  int   rec_cycles = 0;
  bit   rec_stable = 1'b1;

  always @(negedge clk) begin
    logic exp_stall, grant, ok;
    exp_t e;
    exp_stall = ((dm_re | dm_we) & ~dm_done) | (if_re & ~if_done);
    ok = (stall === exp_stall) && (!err || dm_done || if_done) && !(dm_done && if_done)
         && !(dm_done && p_dm_done) && !(if_done && p_if_done);
    check("cycle", ok, $sformatf("stall=%b want %b err=%b dm_done=%b if_done=%b",
                                 stall, exp_stall, err, dm_done, if_done));

    grant = mem_req && !p_req;
    if (p_rst) starve = 0;
    else begin
      if (grant && mem_addr[15])
        check("grant_data", p_dm_elig && !(p_if_elig && starve == STARVE_MAX),
              $sformatf("data granted: dm_elig=%b if_elig=%b starve=%0d", p_dm_elig, p_if_elig, starve));
      if (grant && !mem_addr[15])
        check("grant_fetch", p_if_elig && (!p_dm_elig || starve == STARVE_MAX),
              $sformatf("fetch granted: dm_elig=%b if_elig=%b starve=%0d", p_dm_elig, p_if_elig, starve));
      if (!p_if_re) starve = 0;
      else if (grant && !mem_addr[15]) starve = 0;
      else if (grant && p_if_elig && starve < STARVE_MAX) starve++;
    end

    if (mem_req) begin
      if (!p_req) begin
        rec_addr = mem_addr; rec_we = mem_we; rec_wdata = mem_wdata;
        rec_cycles = 1; rec_stable = 1'b1;
      end else begin
        rec_cycles++;
        if (mem_addr !== rec_addr || mem_we !== rec_we || (rec_we && mem_wdata !== rec_wdata))
          rec_stable = 1'b0;
      end
    end

    if (dm_done) begin
      check("dm_done_expected", dq.size() != 0, "dm_done with no outstanding data access");
      if (dq.size() != 0) begin
        e = dq.pop_front();
        check("dm_result", dm_out === e.out && err === e.err,
              $sformatf("dm_out=%h err=%b want %h/%b", dm_out, err, e.out, e.err));
        check("dm_access", rec_addr === e.addr && rec_we === e.we && (!e.we || rec_wdata === e.wdata)
              && rec_stable && p_req && rec_cycles == (e.err ? TIMEOUT : last_lat + 1),
              $sformatf("addr=%h we=%b wd=%h stable=%b cycles=%0d want %h/%b/%h lat=%0d",
                        rec_addr, rec_we, rec_wdata, rec_stable, rec_cycles, e.addr, e.we, e.wdata, last_lat));
      end
    end
    if (if_done) begin
      check("if_done_expected", iq.size() != 0, "if_done with no outstanding fetch");
      if (iq.size() != 0) begin
        e = iq.pop_front();
        check("if_result", instr_out === e.out && err === e.err,
              $sformatf("instr_out=%h err=%b want %h/%b", instr_out, err, e.out, e.err));
        check("if_access", rec_addr === e.addr && rec_we === 1'b0 && rec_stable && p_req
              && rec_cycles == (e.err ? TIMEOUT : last_lat + 1),
              $sformatf("addr=%h we=%b stable=%b cycles=%0d want %h lat=%0d",
                        rec_addr, rec_we, rec_stable, rec_cycles, e.addr, last_lat));
      end
    end

    p_req     = mem_req;
    p_dm_done = dm_done;
    p_if_done = if_done;
    p_rst     = rst;
    p_if_re   = if_re;
    p_dm_elig = (dm_re | dm_we) & ~dm_done;
    p_if_elig = if_re & ~if_done;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic data_thread();
    logic [15:0] exp_dm, a, d;
    int op, wait_cnt;
    bit to;
    exp_t e;
    exp_dm = '0;
    for (int i = 0; i < N_OPS; i++) begin
      op = $urandom_range(0, 2);
      to = (i == 5) || ($urandom_range(0, 29) == 0);
      a  = to ? {8'h90, 8'($urandom)} : {8'h80, 8'($urandom)};
      d  = 16'($urandom);
      repeat ($urandom_range(0, 2)) tick();
      dm_re = (op != 1); dm_we = (op != 0); dm_addr = a; dm_in = d;
      if (!to && op == 0) exp_dm = ref_mem[a[7:0]];
      if (!to && op != 0) ref_mem[a[7:0]] = d;
      e.addr = a; e.we = (op != 0); e.wdata = d; e.out = exp_dm; e.err = to;
      dq.push_back(e);
      wait_cnt = 0;
      do begin tick(); wait_cnt++; end while (!dm_done && wait_cnt < WAIT_MAX);
      dm_re = 1'b0; dm_we = 1'b0;
      if (!dm_done) begin
        check("dm_wait", dm_done, "no dm_done within cycle budget");
        return;
      end
    end
  endtask

  task automatic fetch_thread();
    logic [15:0] exp_if, a;
    int wait_cnt;
    bit to;
    exp_t e;
    exp_if = '0;
    for (int i = 0; i < N_OPS; i++) begin
      to = (i == 5) || ($urandom_range(0, 29) == 0);
      a  = to ? {8'h10, 8'($urandom)} : {8'h00, 8'($urandom)};
      repeat ($urandom_range(0, 2)) tick();
      if_re = 1'b1; if_addr = a;
      if (!to) exp_if = code_word(a);
      e.addr = a; e.we = 1'b0; e.wdata = '0; e.out = exp_if; e.err = to;
      iq.push_back(e);
      wait_cnt = 0;
      do begin tick(); wait_cnt++; end while (!if_done && wait_cnt < WAIT_MAX);
      if_re = 1'b0;
      if (!if_done) begin
        check("if_wait", if_done, "no if_done within cycle budget");
        return;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int wait_cnt, dones;
    for (int i = 0; i < 256; i++) begin
      phys_mem[i] = 16'($urandom);
      ref_mem[i]  = phys_mem[i];
    end
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    check("reset_state", mem_req === 1'b0 && mem_we === 1'b0 && mem_addr === 16'h0 && mem_wdata === 16'h0
          && dm_out === 16'h0 && instr_out === 16'h0 && dm_done === 1'b0 && if_done === 1'b0
          && err === 1'b0 && stall === 1'b0,
          $sformatf("req=%b we=%b addr=%h wd=%h dm_out=%h instr=%h done=%b/%b err=%b stall=%b",
                    mem_req, mem_we, mem_addr, mem_wdata, dm_out, instr_out, dm_done, if_done, err, stall));
    tick();

    fork
      data_thread();
      fetch_thread();
    join

    // Reset in the middle of an access that will never complete.
    tick();
    dm_re = 1'b1; dm_we = 1'b0; dm_addr = 16'h9042;
    wait_cnt = 0;
    do begin tick(); wait_cnt++; end while (!mem_req && wait_cnt < 20);
    repeat (10) tick();
    check("busy_before_reset", mem_req === 1'b1 && stall === 1'b1,
          $sformatf("mem_req=%b stall=%b before reset", mem_req, stall));
    rst = 1'b1; dm_re = 1'b0;
    tick();
    check("reset_mid_busy", mem_req === 1'b0 && dm_done === 1'b0 && err === 1'b0
          && dm_out === 16'h0 && instr_out === 16'h0,
          $sformatf("req=%b done=%b err=%b dm_out=%h instr=%h", mem_req, dm_done, err, dm_out, instr_out));
    rst = 1'b0;
    dones = 0;
    repeat (10) begin tick(); if (dm_done || if_done || mem_req) dones++; end
    check("no_done_after_reset", dones == 0, $sformatf("%0d cycles with done/req after reset", dones));

    check("scoreboard_drained", dq.size() == 0 && iq.size() == 0,
          $sformatf("%0d data / %0d fetch results outstanding", dq.size(), iq.size()));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
